// File: rtl/csa_iter_mul.sv
// csa_iter_mul: iterative RV32M/RV64M multiplier using carry-save accumulation.
// Folds RADIX_BITS partial products per cycle into a redundant S/C pair
// through chained 3:2 rows, then resolves with one carry-propagate add.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous kill of any operation in flight
//   in_valid/in_ready   operand handshake (in_ready high only when idle)
//   op                  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1, rs2, in_tag    multiplicand, multiplier, writeback tag
//   out_valid/out_ready result handshake
//   result, out_tag     selected product half and its tag (registered)
module csa_iter_mul #(
   parameter int XLEN       = 32,
   parameter int RADIX_BITS = 2,
   parameter int TAG_W      = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int W2    = 2 * XLEN;
   localparam int N     = XLEN / RADIX_BITS;
   localparam int CW    = $clog2(N) + 1;
   localparam int SHW   = $clog2(W2);
   localparam int LOG_R = $clog2(RADIX_BITS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_RESOLVE,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [W2-1:0]    mcand_q, mcand_d;
   logic [W2-1:0]    s_q, s_d;
   logic [W2-1:0]    c_q, c_d;
   logic [XLEN-1:0]  mplier_q, mplier_d;
   logic             neg_q, neg_d;
   logic [1:0]       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic             out_valid_q, out_valid_d;

   logic [W2-1:0]    acc_s, acc_c;
   logic [W2-1:0]    pp, t_s, t_c;
   logic [SHW-1:0]   sh;
   logic [W2-1:0]    corr, r_s, r_c, prod;
   logic             accept;

   assign in_ready  = (state_q == S_IDLE);
   assign accept    = in_ready && in_valid && !flush;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign out_tag   = out_tag_q;

   // Next state
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:    if (in_valid) state_d = S_ACC;
            S_ACC:     if (cnt_q == CW'(N - 1)) state_d = S_RESOLVE;
            S_RESOLVE: state_d = S_DONE;
            S_DONE:    if (out_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // One ACC step: RADIX_BITS chained 3:2 rows, no carry propagation.
   always_comb begin
      acc_s = s_q;
      acc_c = c_q;
      pp    = '0;
      t_s   = '0;
      t_c   = '0;
      sh    = '0;
      for (int j = 0; j < RADIX_BITS; j++) begin
         sh    = (SHW'(cnt_q) << LOG_R) + SHW'(j);
         pp    = (mcand_q & {W2{mplier_q[j]}}) << sh;
         t_s   = acc_s ^ acc_c ^ pp;
         t_c   = ((acc_s & acc_c) | (acc_s & pp) | (acc_c & pp)) << 1;
         acc_s = t_s;
         acc_c = t_c;
      end
   end

   // The multiplier was summed as unsigned; a negative signed multiplier
   // is fixed up by subtracting mcand weighted by 2^XLEN.
   always_comb begin
      corr = '0;
      if (neg_q) corr = ~(mcand_q << XLEN) + W2'(1);
      r_s  = s_q ^ c_q ^ corr;
      r_c  = ((s_q & c_q) | (s_q & corr) | (c_q & corr)) << 1;
      prod = r_s + r_c;
   end

   // Datapath next state
   always_comb begin
      mcand_d     = mcand_q;
      s_d         = s_q;
      c_d         = c_q;
      mplier_d    = mplier_q;
      neg_d       = neg_q;
      op_d        = op_q;
      tag_d       = tag_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      out_tag_d   = out_tag_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         if (op == 2'b01 || op == 2'b10)
            mcand_d = {{XLEN{rs1[XLEN-1]}}, rs1};
         else
            mcand_d = {{XLEN{1'b0}}, rs1};
         mplier_d = rs2;
         neg_d    = (op == 2'b01) && rs2[XLEN-1];
         op_d     = op;
         tag_d    = in_tag;
         s_d      = '0;
         c_d      = '0;
         cnt_d    = '0;
      end else if (!flush) begin
         unique case (state_q)
            S_ACC: begin
               s_d      = acc_s;
               c_d      = acc_c;
               mplier_d = mplier_q >> RADIX_BITS;
               cnt_d    = cnt_q + CW'(1);
            end
            S_RESOLVE: begin
               if (op_q == 2'b00)
                  result_d = prod[XLEN-1:0];
               else
                  result_d = prod[W2-1:XLEN];
               out_tag_d   = tag_q;
               out_valid_d = 1'b1;
            end
            S_DONE: if (out_ready) out_valid_d = 1'b0;
            default: ;
         endcase
      end
      if (flush) out_valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         s_q         <= '0;
         c_q         <= '0;
         mplier_q    <= '0;
         neg_q       <= 1'b0;
         op_q        <= '0;
         tag_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         out_tag_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         s_q         <= s_d;
         c_q         <= c_d;
         mplier_q    <= mplier_d;
         neg_q       <= neg_d;
         op_q        <= op_d;
         tag_q       <= tag_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         out_tag_q   <= out_tag_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_csa_iter_mul.sv
// tb_csa_iter_mul: bench for csa_iter_mul, three radix variants side by side.
// Directed cases on RADIX_BITS=2, random regression on 1, 2 and 4.
module tb_csa_iter_mul;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [4:0]  in_tag = '0;

   logic        ir [3];
   logic        ov [3];
   logic [31:0] res [3];
   logic [4:0]  otag [3];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   csa_iter_mul #(.XLEN(32), .RADIX_BITS(1), .TAG_W(5)) u_r1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(ir[0]), .op(op), .rs1(rs1), .rs2(rs2), .in_tag(in_tag),
      .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]),
      .out_tag(otag[0]));

   csa_iter_mul #(.XLEN(32), .RADIX_BITS(2), .TAG_W(5)) u_r2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(ir[1]), .op(op), .rs1(rs1), .rs2(rs2), .in_tag(in_tag),
      .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]),
      .out_tag(otag[1]));

   csa_iter_mul #(.XLEN(32), .RADIX_BITS(4), .TAG_W(5)) u_r4 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(ir[2]), .op(op), .rs1(rs1), .rs2(rs2), .in_tag(in_tag),
      .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]),
      .out_tag(otag[2]));

   function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
      p  = ea * eb;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] pick_operand();
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h0000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t);
      op = o;
      rs1 = a;
      rs2 = b;
      in_tag = t;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // lat = rising edges since the accept edge when out_valid is first seen.
   task automatic wait_out(input int k, output int lat, output bit ok);
      lat = 0;
      ok = 1'b0;
      while (lat < 200) begin
         if (ov[k]) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total++;
      if (ir[1] !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %b want 1", ir[1]);
      end
      total++;
      if (ov[1] !== 1'b0) begin
         bad++;
         $display("FAIL reset_out_valid: got %b want 0", ov[1]);
      end
      total++;
      if (res[1] !== 32'h0) begin
         bad++;
         $display("FAIL reset_result: got %h want 0", res[1]);
      end
      total++;
      if (otag[1] !== 5'h0) begin
         bad++;
         $display("FAIL reset_out_tag: got %h want 0", otag[1]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [1:0]  t_op [6];
      logic [31:0] t_a [6];
      logic [31:0] t_b [6];
      logic [31:0] t_e [6];
      int lat;
      bit ok;
      t_op = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
      t_a  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003};
      t_b  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
      t_e  = '{32'hFFFFFFFE, 32'h00000001, 32'h40000000,
               32'h00000000, 32'hFFFFFFFF, 32'h00000001};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         issue(t_op[i], t_a[i], t_b[i], 5'(i + 1));
         wait_out(1, lat, ok);
         total++;
         if (!ok || res[1] !== t_e[i]) begin
            bad++;
            $display("FAIL directed_result[%0d]: got %h want %h", i,
                     res[1], t_e[i]);
         end
         total++;
         if (lat != 17) begin
            bad++;
            $display("FAIL directed_latency[%0d]: got %0d want 17", i, lat);
         end
         total++;
         if (otag[1] !== 5'(i + 1)) begin
            bad++;
            $display("FAIL directed_tag[%0d]: got %0d want %0d", i,
                     otag[1], i + 1);
         end
         @(posedge clk);
         @(negedge clk);
         total++;
         if (ir[1] !== 1'b1 || ov[1] !== 1'b0) begin
            bad++;
            $display("FAIL directed_idle[%0d]: in_ready=%b out_valid=%b want 1/0",
                     i, ir[1], ov[1]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b, e;
      int lat;
      bit ok;
      a = $urandom;
      b = $urandom;
      e = ref_mul(2'b00, a, b);
      out_ready = 1'b0;
      issue(2'b00, a, b, 5'd9);
      wait_out(1, lat, ok);
      total++;
      if (!ok || res[1] !== e) begin
         bad++;
         $display("FAIL bp_result: got %h want %h", res[1], e);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         total++;
         if (ov[1] !== 1'b1 || res[1] !== e || otag[1] !== 5'd9 ||
             ir[1] !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold[%0d]: v=%b r=%h t=%0d rdy=%b want 1/%h/9/0",
                     i, ov[1], res[1], otag[1], ir[1], e);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (ov[1] !== 1'b0 || ir[1] !== 1'b1) begin
         bad++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1",
                  ov[1], ir[1]);
      end
      a = $urandom;
      b = $urandom;
      e = ref_mul(2'b01, a, b);
      issue(2'b01, a, b, 5'd17);
      wait_out(1, lat, ok);
      total++;
      if (!ok || res[1] !== e || otag[1] !== 5'd17) begin
         bad++;
         $display("FAIL b2b_result: got %h tag %0d want %h tag 17",
                  res[1], otag[1], e);
      end
      total++;
      if (lat != 17) begin
         bad++;
         $display("FAIL b2b_latency: got %0d want 17", lat);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_flush();
      logic [31:0] prev_r, e;
      logic [4:0]  prev_t;
      bit seen;
      int lat;
      bit ok;
      prev_r = res[1];
      prev_t = otag[1];
      issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      total++;
      if (ir[1] !== 1'b1 || ov[1] !== 1'b0) begin
         bad++;
         $display("FAIL flush_acc_idle: in_ready=%b out_valid=%b want 1/0",
                  ir[1], ov[1]);
      end
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk);
         @(negedge clk);
         seen |= ov[1];
      end
      total++;
      if (seen !== 1'b0 || res[1] !== prev_r || otag[1] !== prev_t) begin
         bad++;
         $display("FAIL flush_acc_quiet: valid_seen=%b r=%h t=%0d want 0/%h/%0d",
                  seen, res[1], otag[1], prev_r, prev_t);
      end
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      flush = 1'b0;
      total++;
      if (ir[1] !== 1'b1) begin
         bad++;
         $display("FAIL flush_beats_accept: in_ready=%b want 1", ir[1]);
      end
      e = ref_mul(2'b10, 32'hDEAD_BEEF, 32'h0000_0007);
      out_ready = 1'b0;
      issue(2'b10, 32'hDEAD_BEEF, 32'h0000_0007, 5'd12);
      wait_out(1, lat, ok);
      out_ready = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      total++;
      if (!ok || ov[1] !== 1'b0 || ir[1] !== 1'b1 || res[1] !== e ||
          otag[1] !== 5'd12) begin
         bad++;
         $display("FAIL flush_done: v=%b rdy=%b r=%h t=%0d want 0/1/%h/12",
                  ov[1], ir[1], res[1], otag[1], e);
      end
   endtask

   task automatic test_reset_done();
      int lat;
      bit ok;
      out_ready = 1'b0;
      issue(2'b00, 32'd7, 32'd6, 5'd21);
      wait_out(1, lat, ok);
      total++;
      if (!ok || res[1] !== 32'd42) begin
         bad++;
         $display("FAIL rstdone_pre: got %h want 0000002a", res[1]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (ov[1] !== 1'b0 || res[1] !== 32'h0 || otag[1] !== 5'h0 ||
          ir[1] !== 1'b1) begin
         bad++;
         $display("FAIL rstdone_async: v=%b r=%h t=%0d rdy=%b want 0/0/0/1",
                  ov[1], res[1], otag[1], ir[1]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_random();
      int          want_lat [3];
      bit          got [3];
      logic [31:0] gr [3];
      logic [4:0]  gt [3];
      int          gl [3];
      logic [1:0]  o;
      logic [31:0] a, b, e;
      logic [4:0]  t;
      int          cyc;
      want_lat = '{33, 17, 9};
      pulse_reset();
      out_ready = 1'b1;
      for (int it = 0; it < 40; it++) begin
         o = 2'($urandom_range(0, 3));
         a = pick_operand();
         b = pick_operand();
         t = 5'($urandom_range(0, 31));
         e = ref_mul(o, a, b);
         total++;
         if (ir[0] !== 1'b1 || ir[1] !== 1'b1 || ir[2] !== 1'b1) begin
            bad++;
            $display("FAIL rnd_ready[%0d]: got %b%b%b want 111", it,
                     ir[0], ir[1], ir[2]);
         end
         issue(o, a, b, t);
         got = '{1'b0, 1'b0, 1'b0};
         cyc = 0;
         while (cyc < 200) begin
            for (int k = 0; k < 3; k++) begin
               if (ov[k] && !got[k]) begin
                  got[k] = 1'b1;
                  gr[k] = res[k];
                  gt[k] = otag[k];
                  gl[k] = cyc;
               end
            end
            if (got[0] && got[1] && got[2]) break;
            @(posedge clk);
            cyc++;
            @(negedge clk);
         end
         for (int k = 0; k < 3; k++) begin
            total++;
            if (!got[k] || gr[k] !== e || gt[k] !== t) begin
               bad++;
               $display("FAIL rnd_result[%0d] k=%0d op=%0d a=%h b=%h: got %h tag %0d want %h tag %0d",
                        it, k, o, a, b, gr[k], gt[k], e, t);
            end
            total++;
            if (!got[k] || gl[k] != want_lat[k]) begin
               bad++;
               $display("FAIL rnd_latency[%0d] k=%0d: got %0d want %0d",
                        it, k, gl[k], want_lat[k]);
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_flush();
      test_reset_done();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
